// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and keeps at most one imem request in flight.
// Returned words are queued with their PCs in a small prefetch FIFO that feeds IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        out_pc_q, out_pc_d;
    logic               outstanding_q, outstanding_d;
    logic               drop_q, drop_d;

    logic               fifo_valid;
    logic               issue;
    logic               ack_valid;
    logic               push;
    logic               pop;
    entry_t             head;

    // An issue only happens with nothing in flight and a free slot, so a push never meets a full FIFO.
    assign fifo_valid = (count_q != '0);
    assign issue      = !outstanding_q && (count_q < CNT_W'(FIFO_DEPTH)) && !redirect;
    assign ack_valid  = imem_ack && outstanding_q;
    assign push       = ack_valid && !drop_q && !redirect;
    assign pop        = fifo_valid && ready_in && !redirect;
    assign head       = fifo_q[rd_ptr_q];

    assign imem_req        = issue && !rst;
    assign imem_addr       = fetch_pc_q;
    assign valid_out       = fifo_valid;
    assign pc_out          = fifo_valid ? head.pc    : '0;
    assign instruction_out = fifo_valid ? head.instr : '0;

    // Next-state: redirect overrides issue, push and pop.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_pc_d      = out_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            // A request still in flight must have its response discarded when it lands.
            outstanding_d = outstanding_q && !imem_ack;
            drop_d        = outstanding_q && !imem_ack;
        end else begin
            if (issue) begin
                outstanding_d = 1'b1;
                out_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (ack_valid) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            out_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_pc_q      <= out_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Payload storage needs no reset: the masked outputs never expose an empty slot.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {out_pc_q, imem_rdata};
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage ahead of the IF/ID pipeline register. Owns the fetch PC, issues single-word requests to instruction memory, and buffers returned instructions with their PCs in a small prefetch FIFO. The FIFO head drives the IF/ID register's pc/instruction/valid inputs. Branch/jump redirects flush the FIFO and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- imem_req  output  1  issue a fetch this cycle; accepted unconditionally
- imem_addr  output  32  word-aligned fetch address; valid while imem_req=1
- imem_ack  input  1  response strobe for the single outstanding request
- imem_rdata  input  32  instruction word, valid while imem_ack=1
- redirect  input  1  control-flow change; flushes the fetch stream
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0
- ready_in  input  1  downstream enable; head entry consumed when valid_out && ready_in
- pc_out  output  32  PC of the FIFO head
- instruction_out  output  32  instruction at the FIFO head
- valid_out  output  1  FIFO non-empty

## Operation
- State: fetch_pc (32), outstanding flag, outstanding_pc (32), drop flag, FIFO of {pc, instr}, count 0..FIFO_DEPTH.
- Issue: imem_req = !outstanding && (count < FIFO_DEPTH) && !redirect. imem_addr = fetch_pc, combinational. On issue: outstanding←1, outstanding_pc←fetch_pc, fetch_pc←fetch_pc+4, mod 2^32: 0xFFFF_FFFC wraps to 0. At most one request is outstanding.
- Space accounting: issue requires count < FIFO_DEPTH with nothing outstanding, so a push never meets a full FIFO.
- Response: imem_ack while outstanding: outstanding←0. If drop=1 or redirect=1 this cycle, discard the data and clear drop. Otherwise push {outstanding_pc, imem_rdata}. imem_ack while not outstanding: ignored entirely.
- Consume: pop head when valid_out && ready_in && !redirect.
- Simultaneous push and pop: both apply and count is unchanged. Entry order is preserved.
- Redirect has priority over everything. In that cycle:
  - FIFO emptied (count←0);
  - fetch_pc←{redirect_pc[31:2],2'b00};
  - no issue;
  - if outstanding and no ack this cycle, drop←1.
- After a redirect, fetching resumes once outstanding=0, starting at the redirected PC.
- Back-to-back redirects: the last one wins. drop stays set while a request is still in flight.
- Empty FIFO: valid_out=0 and pc_out=instruction_out=0. Outputs are masked, so stale storage is never visible.

## Timing
- Reset (asynchronous, immediate) values:
  - imem_req=0 while rst=1; imem_addr=RESET_PC;
  - valid_out=0, pc_out=0, instruction_out=0;
  - fetch_pc=RESET_PC, outstanding=0, drop=0, count=0.
- First request: imem_req=1 in the first cycle after rst deasserts.
- Response latency L ≥ 1 cycle after the issue edge. The memory must not ack in the issue cycle.
- Push latency: ack in cycle T gives valid_out=1 with that entry in cycle T+1 (if it lands at the head).
- Throughput: one instruction per L+1 cycles, because only one request is in flight. With ready_in=0, fetching stops when count + outstanding reaches FIFO_DEPTH.
- Redirect in cycle T:
  - valid_out=0 in T+1;
  - if nothing was outstanding after T, imem_req=1 with addr=redirect_pc in T+1;
  - first redirected instruction visible no earlier than T+1+L+1.
- Reset mid-operation: all in-flight state is lost. A late ack arriving after reset is ignored because outstanding=0.

## Test plan
- Reset release, RESET_PC=0x100, L=1, ready_in=1 -> imem_addr sequence 0x100, 0x104, 0x108…; outputs pc_out 0x100, 0x104, … each with the matching word, every 2 cycles, no gaps or duplicates.
- ready_in=0 for 12 cycles, L=1, DEPTH=2 -> count reaches 2 and imem_req stays 0. Head holds pc_out=0x100. On release, 0x100 then 0x104 drain in order, then 0x108 is fetched.
- Redirect to 0x2000 while request for 0x108 is outstanding (L=3) -> ack for 0x108 is discarded. Next imem_addr is 0x2000, and the next valid_out carries pc_out=0x2000.
- Redirect to 0x2000 in the same cycle as imem_ack -> word discarded, FIFO empty, imem_req=1 addr=0x2000 on the next cycle.
- redirect_pc=0x2003 -> imem_addr=0x2000. redirect_pc=0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst with FIFO full and a request outstanding -> valid_out/pc_out/instruction_out go to 0 immediately. After release, a stray imem_ack is ignored, and the first fetch is RESET_PC.
